// File: rtl/flow_source_pkg.sv
// Shared definitions for the flow-control transmit path.
// State codes are visible on the estado debug port.
package flow_source_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_SEND  = 2'b01,
        S_PAUSE = 2'b10,
        S_ERROR = 2'b11
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/flow_source.sv
// Transmit side of the flow-control loop: upstream stream -> FIFO write port.
// A word taken in the cycle before a stop is still pushed; FIFO margin absorbs it.
module flow_source
    import flow_source_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic              pausa,
    input  logic              continuar,
    input  logic              error_full,
    input  logic              idle,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  words_sent,
    output logic              overflow_seen,
    output logic [1:0]        estado
);

    state_e            state_q;
    state_e            state_d;
    logic              push_q;
    logic [DATA_W-1:0] data_q;
    logic              ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: begin
                if (iniciar) state_d = S_SEND;
            end
            S_SEND: begin
                if (error_full)  state_d = S_ERROR;
                else if (pausa)  state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (error_full)                state_d = S_ERROR;
                else if (pausa)                state_d = S_PAUSE;
                else if (continuar || idle)    state_d = S_SEND;
            end
            S_ERROR: begin
                if (idle && !error_full) state_d = S_SEND;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Only S_SEND accepts, and never in the cycle a stop request arrives.
    always_comb begin
        ready_out = 1'b0;
        if (state_q == S_SEND) begin
            ready_out = !error_full && !pausa;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q <= 1'b0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            push_q <= valid_in && ready_out;
            if (valid_in && ready_out) begin
                data_q <= data_in;
            end
            if (state_d == S_ERROR) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_words (
        .clk     (clk),
        .clear_i (reset),
        .inc_i   (push_q),
        .count_o (words_sent)
    );

    assign push          = push_q;
    assign data_out      = data_q;
    assign overflow_seen = ovf_q;
    assign estado        = state_q;

endmodule

// File: tb/tb_flow_source.sv
// Directed bench for flow_source: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_flow_source;

    logic        clk = 1'b0;
    logic        reset, iniciar, valid_in;
    logic [7:0]  data_in;
    logic        pausa, continuar, error_full, idle;

    logic        ready_out, push, overflow_seen;
    logic [7:0]  data_out;
    logic [15:0] words_sent;
    logic [1:0]  estado;

    logic        s_ready, s_push, s_ovf;
    logic [7:0]  s_data;
    logic [3:0]  s_words;
    logic [1:0]  s_estado;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    flow_source u_dut (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (ready_out),
        .pausa         (pausa),
        .continuar     (continuar),
        .error_full    (error_full),
        .idle          (idle),
        .push          (push),
        .data_out      (data_out),
        .words_sent    (words_sent),
        .overflow_seen (overflow_seen),
        .estado        (estado)
    );

    flow_source #(.DATA_W(8), .CNT_W(4)) u_sat (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (s_ready),
        .pausa         (pausa),
        .continuar     (continuar),
        .error_full    (error_full),
        .idle          (idle),
        .push          (s_push),
        .data_out      (s_data),
        .words_sent    (s_words),
        .overflow_seen (s_ovf),
        .estado        (s_estado)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        pausa = 1'b0; continuar = 1'b0; error_full = 1'b0; idle = 1'b0;
        tick();
        tick();
        chk("rst_estado", estado, 2'b00);
        chk("rst_push", push, 1'b0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_words", words_sent, 16'd0);
        chk("rst_ovf", overflow_seen, 1'b0);
        chk("rst_ready", ready_out, 1'b0);

        reset = 1'b0;
        valid_in = 1'b1;
        tick();
        chk("init_ready", ready_out, 1'b0);
        chk("init_nopush", push, 1'b0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("send_estado", estado, 2'b01);

        // 0x01..0x05 back to back
        for (int i = 1; i <= 5; i++) begin
            data_in = 8'(i);
            #1;
            chk("stream_ready", ready_out, 1'b1);
            tick();
            chk("stream_push", push, 1'b1);
            chk("stream_data", data_out, 32'(i));
        end
        valid_in = 1'b0;
        tick();
        chk("stream_idle_push", push, 1'b0);
        chk("stream_hold_data", data_out, 8'h05);
        chk("stream_words", words_sent, 16'd5);

        // pausa for 3 cycles, then continuar
        valid_in = 1'b1; data_in = 8'h10; pausa = 1'b1;
        #1;
        chk("pausa_ready", ready_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pausa_push", push, 1'b0);
            chk("pausa_estado", estado, 2'b10);
        end
        pausa = 1'b0; continuar = 1'b1; data_in = 8'h11;
        #1;
        chk("cont_ready_pause", ready_out, 1'b0);
        tick();
        continuar = 1'b0;
        chk("cont_push0", push, 1'b0);
        chk("cont_estado", estado, 2'b01);
        chk("cont_ready", ready_out, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("resume_push", push, 1'b1);
        chk("resume_data", data_out, 8'h11);
        tick();
        chk("resume_words", words_sent, 16'd6);

        // error_full pulse, idle low for 4 cycles
        chk("pre_err_ovf", overflow_seen, 1'b0);
        error_full = 1'b1;
        tick();
        error_full = 1'b0;
        chk("err_estado0", estado, 2'b11);
        chk("err_ovf", overflow_seen, 1'b1);
        valid_in = 1'b1;
        #1;
        chk("err_ready", ready_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_estado", estado, 2'b11);
            chk("err_push", push, 1'b0);
        end
        valid_in = 1'b0; idle = 1'b1;
        tick();
        idle = 1'b0;
        chk("err_exit", estado, 2'b01);
        chk("ovf_sticky", overflow_seen, 1'b1);

        // priority: pausa over continuar, error_full over pausa
        pausa = 1'b1; continuar = 1'b1;
        tick();
        chk("prio_pausa", estado, 2'b10);
        pausa = 1'b0;
        tick();
        continuar = 1'b0;
        chk("prio_back", estado, 2'b01);
        error_full = 1'b1; pausa = 1'b1;
        tick();
        chk("prio_err", estado, 2'b11);
        error_full = 1'b0; pausa = 1'b0; idle = 1'b1;
        tick();
        idle = 1'b0;
        chk("prio_exit", estado, 2'b01);
        chk("prio_ovf", overflow_seen, 1'b1);

        // saturation: fresh start, 20 transfers
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_ovf", overflow_seen, 1'b0);
        chk("rst2_words", s_words, 4'd0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        valid_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            data_in = 8'(i + 32);
            tick();
        end
        chk("sat_data", s_data, 8'd52);
        valid_in = 1'b0;
        tick();
        chk("sat_words4", s_words, 4'd15);
        chk("sat_words16", words_sent, 16'd20);

        // reset during a transfer, with iniciar also high
        valid_in = 1'b1; data_in = 8'hAA;
        tick();
        chk("pre_rst_push", push, 1'b1);
        chk("pre_rst_data", data_out, 8'hAA);
        reset = 1'b1; iniciar = 1'b1;
        tick();
        chk("midrst_push", push, 1'b0);
        chk("midrst_words", words_sent, 16'd0);
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_estado", estado, 2'b00);
        chk("midrst_ready", ready_out, 1'b0);
        reset = 1'b0; iniciar = 1'b0; valid_in = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
